// File: rtl/key_pkg.sv
// key_pkg: shared state encoding and default timing constants for the key debouncer
package key_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILT_DN = 2'd1,
        DOWN    = 2'd2,
        FILT_UP = 2'd3
    } state_t;

    localparam logic [19:0] CNT_MAX_DEF  = 20'd999_999;
    localparam logic [25:0] LONG_MAX_DEF = 26'd49_999_999;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer, resets to 1 (idle level of an active-low key)
//   clk   in  system clock
//   rst_n in  synchronous active-low reset
//   d     in  asynchronous input
//   q     out synchronized output
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) {q, meta} <= 2'b11;
        else        {q, meta} <= {meta, d};
    end

endmodule

// File: rtl/key_debounce_fsm.sv
// key_debounce_fsm: debounces an active-low push-button into level and pulse outputs
//   clk         in  system clock
//   rst_n       in  synchronous active-low reset
//   key         in  raw asynchronous button, 0 = pressed
//   key_press   out one-cycle pulse on debounced press
//   key_release out one-cycle pulse on debounced release
//   key_state   out debounced level, 1 = held
//   key_long    out one-cycle pulse after LONG_MAX+1 held cycles (macro KEY_LONG_PRESS_EN, else 0)
module key_debounce_fsm
    import key_pkg::*;
#(
    parameter logic [19:0] CNT_MAX  = CNT_MAX_DEF,
    parameter logic [25:0] LONG_MAX = LONG_MAX_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic key_press,
    output logic key_release,
    output logic key_state,
    output logic key_long
);

    state_t      state, state_n;
    logic [19:0] cnt, cnt_n;
    logic        key_s;
    logic        enter_down, enter_idle;

    sync_2ff u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (key),
        .q    (key_s)
    );

    // The counter only runs inside the filter states and is cleared on every
    // transition, so it saturates at CNT_MAX instead of wrapping.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (!key_s) begin
                    state_n = FILT_DN;
                    cnt_n   = '0;
                end
            end
            FILT_DN: begin
                if (key_s) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_n = DOWN;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 20'd1;
                end
            end
            DOWN: begin
                if (key_s) begin
                    state_n = FILT_UP;
                    cnt_n   = '0;
                end
            end
            FILT_UP: begin
                if (!key_s) begin
                    state_n = DOWN;
                    cnt_n   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 20'd1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign enter_down = (state == FILT_DN) && (state_n == DOWN);
    assign enter_idle = (state == FILT_UP) && (state_n == IDLE);
    assign key_state  = (state == DOWN) || (state == FILT_UP);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            key_press   <= enter_down;
            key_release <= enter_idle;
        end
    end

`ifdef KEY_LONG_PRESS_EN
    logic [25:0] long_cnt;
    logic        long_fired;

    // long_cnt is 0 in the first held cycle, so it sits at LONG_MAX during the
    // (LONG_MAX+1)th held cycle; the pulse follows that cycle, once per press.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            long_cnt   <= '0;
            long_fired <= 1'b0;
            key_long   <= 1'b0;
        end else begin
            key_long <= key_state && !long_fired && (long_cnt == LONG_MAX);
            if (enter_down) begin
                long_cnt   <= '0;
                long_fired <= 1'b0;
            end else if (key_state) begin
                long_cnt   <= (long_cnt == LONG_MAX) ? long_cnt : long_cnt + 26'd1;
                long_fired <= long_fired || (long_cnt == LONG_MAX);
            end
        end
    end
`else
    assign key_long = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce_fsm.sv
// tb_key_debounce_fsm: directed self-checking bench for key_debounce_fsm (CNT_MAX=9, LONG_MAX=49)
module tb_key_debounce_fsm;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic key = 1'b1;
    logic key_press, key_release, key_state, key_long;

    int vectors = 0, miscompares = 0;
    int cyc = 0, n_press = 0, n_release = 0, n_long = 0, n_both = 0;
    int press_cyc = 0, long_cyc = 0;

    key_debounce_fsm #(.CNT_MAX(20'd9), .LONG_MAX(26'd49)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key        (key),
        .key_press  (key_press),
        .key_release(key_release),
        .key_state  (key_state),
        .key_long   (key_long)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Pulse counters sampled mid-cycle; counting high cycles catches stretched pulses.
    always @(negedge clk) begin
        if (key_press !== 1'b0) begin n_press++; press_cyc = cyc; end
        if (key_release !== 1'b0) n_release++;
        if (key_press === 1'b1 && key_release === 1'b1) n_both++;
        if (key_long !== 1'b0) begin n_long++; long_cyc = cyc; end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        key   = 1'b1;
        tick(3);
        check("rst_press", key_press, 0);
        check("rst_release", key_release, 0);
        check("rst_state", key_state, 0);
        check("rst_long", key_long, 0);
        rst_n = 1'b1;
        tick(3);
        check("idle_state", key_state, 0);

        repeat (4) begin
            key = 1'b0;
            tick(5);
            key = 1'b1;
            tick(5);
        end
        tick(10);
        check("bounce_no_press", n_press, 0);
        check("bounce_state", key_state, 0);

        key = 1'b0;
        tick(12);
        check("press_early", key_press, 0);
        check("press_early_state", key_state, 0);
        tick(1);
        check("press_pulse", key_press, 1);
        check("press_state", key_state, 1);
        tick(1);
        check("press_one_cycle", key_press, 0);
        check("press_held_state", key_state, 1);
        tick(86);
        check("press_count", n_press, 1);
        check("held_state", key_state, 1);
`ifdef KEY_LONG_PRESS_EN
        check("long_count", n_long, 1);
        check("long_delay", long_cyc - press_cyc, 50);
`else
        check("long_absent", n_long, 0);
`endif

        key = 1'b1;
        tick(3);
        key = 1'b0;
        tick(15);
        check("rel_bounce_state", key_state, 1);
        check("rel_bounce_no_release", n_release, 0);

        key = 1'b1;
        tick(12);
        check("release_early", key_release, 0);
        check("release_early_state", key_state, 1);
        tick(1);
        check("release_pulse", key_release, 1);
        check("release_state", key_state, 0);
        tick(1);
        check("release_one_cycle", key_release, 0);
        tick(6);
        check("release_count", n_release, 1);

        key = 1'b0;
        tick(13);
        check("second_press", key_press, 1);
        tick(2);
        rst_n = 1'b0;
        tick(2);
        check("midrst_state", key_state, 0);
        check("midrst_press", key_press, 0);
        check("midrst_release", key_release, 0);
        rst_n = 1'b1;
        tick(12);
        check("refilter_early", key_press, 0);
        check("refilter_state", key_state, 0);
        tick(1);
        check("refilter_press", key_press, 1);
        check("refilter_state_hi", key_state, 1);
        tick(3);
        check("total_press", n_press, 3);
        check("total_release", n_release, 1);
        check("never_both", n_both, 0);
`ifdef KEY_LONG_PRESS_EN
        check("total_long", n_long, 1);
`else
        check("total_long", n_long, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
